// File: rtl/counter_updown.sv
// Up/down event counter with programmable ceiling, wrap/saturate boundary, clear/load,
// registered terminal-count pulse and sticky overflow. Optional macro COUNTER_PRESCALE_EN.
module counter_updown #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned MAX_VAL  = 2**WIDTH-1,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO  = '0;

  if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH-1) begin : g_chk_max
    $error("counter_updown: MAX_VAL out of range");
  end
  if (PRESCALE < 2) begin : g_chk_pre
    $error("counter_updown: PRESCALE must be >= 2");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic             w_step;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_ovf_evt;
  logic [WIDTH-1:0] w_step_val;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_term;

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE-1);
  localparam logic [PW-1:0] PRE_ONE  = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] r_pre;

  assign w_step = en && (r_pre == PRE_LAST);

  // Prescaler phase survives en=0 gaps; only clr/load restart it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_pre <= '0;
    else if (clr || load)    r_pre <= '0;
    else if (en)             r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + PRE_ONE;
  end
`else
  assign w_step = en;
`endif

  assign w_at_max  = (r_count == MAX_W);
  assign w_at_zero = (r_count == ZERO);
  assign w_term    = up ? MAX_W : ZERO;
  assign w_ovf_evt = w_step && (up ? w_at_max : w_at_zero);
  assign w_load_val = (load_val > MAX_W) ? MAX_W : load_val;

  always_comb begin
    w_step_val = r_count;
    if (up) begin
      if (!w_at_max)  w_step_val = r_count + ONE;
      else if (!sat)  w_step_val = ZERO;
    end else begin
      if (!w_at_zero) w_step_val = r_count - ONE;
      else if (!sat)  w_step_val = MAX_W;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (load) begin
        r_count <= w_load_val;
        r_tc    <= 1'b0;
      end else if (w_step) begin
        r_count <= w_step_val;
        r_tc    <= (w_step_val == w_term);
      end else begin
        r_tc    <= 1'b0;
      end
      // An overflow step in the same cycle outranks ovf_clr.
      if (!load && w_ovf_evt) r_ovf <= 1'b1;
      else if (ovf_clr)       r_ovf <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_counter_updown.sv
// Vector table + scoreboard bench for counter_updown (6-bit/63 instance and a 4-bit/9 instance).
module tb_counter_updown;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_en, a_up, a_sat, a_clr, a_load, a_ovf_clr;
  logic [5:0] a_lv, a_count;
  logic       a_tc, a_ovf;
  logic       b_en, b_up, b_sat, b_clr, b_load, b_ovf_clr;
  logic [3:0] b_lv, b_count;
  logic       b_tc, b_ovf;

  counter_updown #(.WIDTH(6), .MAX_VAL(63), .PRESCALE(4)) u_dut_a (
    .clk(clk), .rst(rst), .en(a_en), .up(a_up), .sat(a_sat), .clr(a_clr),
    .load(a_load), .load_val(a_lv), .ovf_clr(a_ovf_clr),
    .count(a_count), .tc(a_tc), .ovf(a_ovf));

  counter_updown #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(4)) u_dut_b (
    .clk(clk), .rst(rst), .en(b_en), .up(b_up), .sat(b_sat), .clr(b_clr),
    .load(b_load), .load_val(b_lv), .ovf_clr(b_ovf_clr),
    .count(b_count), .tc(b_tc), .ovf(b_ovf));

  typedef struct {
    string      name;
    logic       b;
    logic       en, up, sat, clr, load, oc;
    logic [5:0] lv;
    logic [5:0] c;
    logic       t, o;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(string n, logic b, logic en, logic up, logic sat, logic clr,
                              logic load, logic oc, int lv, int c, logic t, logic o);
    vec_t v;
    v.name = n; v.b = b; v.en = en; v.up = up; v.sat = sat; v.clr = clr;
    v.load = load; v.oc = oc; v.lv = 6'(lv); v.c = 6'(c); v.t = t; v.o = o;
    return v;
  endfunction

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_en = 0; a_up = 1; a_sat = 0; a_clr = 0; a_load = 0; a_ovf_clr = 0; a_lv = '0;
    b_en = 0; b_up = 1; b_sat = 0; b_clr = 0; b_load = 0; b_ovf_clr = 0; b_lv = '0;
  endtask

  task automatic compare_head();
    vec_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    if (e.b) begin
      chk({e.name, ".count"}, int'(b_count), int'(e.c));
      chk({e.name, ".tc"},    int'(b_tc),    int'(e.t));
      chk({e.name, ".ovf"},   int'(b_ovf),   int'(e.o));
    end else begin
      chk({e.name, ".count"}, int'(a_count), int'(e.c));
      chk({e.name, ".tc"},    int'(a_tc),    int'(e.t));
      chk({e.name, ".ovf"},   int'(a_ovf),   int'(e.o));
    end
  endtask

  task automatic drive_vec(vec_t v);
    @(negedge clk);
    idle_inputs();
    if (v.b) begin
      b_en = v.en; b_up = v.up; b_sat = v.sat; b_clr = v.clr;
      b_load = v.load; b_ovf_clr = v.oc; b_lv = v.lv[3:0];
    end else begin
      a_en = v.en; a_up = v.up; a_sat = v.sat; a_clr = v.clr;
      a_load = v.load; a_ovf_clr = v.oc; a_lv = v.lv;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.count", int'(a_count), 0);
    chk("reset.tc",    int'(a_tc),    0);
    chk("reset.ovf",   int'(a_ovf),   0);
    @(negedge clk);
    rst = 1'b1;

`ifndef COUNTER_PRESCALE_EN
    //            name      b  en up st cl ld oc  lv   c  t  o
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk("t1_up", 0, 1, 1, 0, 0, 0, 0,  0,  i, 0, 0));
    tbl.push_back(mk("t2_ld61",  0, 0, 1, 0, 0, 1, 0, 61, 61, 0, 0));
    tbl.push_back(mk("t2_62",    0, 1, 1, 0, 0, 0, 0,  0, 62, 0, 0));
    tbl.push_back(mk("t2_63",    0, 1, 1, 0, 0, 0, 0,  0, 63, 1, 0));
    tbl.push_back(mk("t2_wrap",  0, 1, 1, 0, 0, 0, 0,  0,  0, 0, 1));
    tbl.push_back(mk("t2_1",     0, 1, 1, 0, 0, 0, 0,  0,  1, 0, 1));
    tbl.push_back(mk("t3_clr",   0, 0, 1, 0, 1, 0, 0,  0,  0, 0, 0));
    tbl.push_back(mk("t3_ld1",   0, 0, 0, 0, 0, 1, 0,  1,  1, 0, 0));
    tbl.push_back(mk("t3_dn0",   0, 1, 0, 0, 0, 0, 0,  0,  0, 1, 0));
    tbl.push_back(mk("t3_dnwr",  0, 1, 0, 0, 0, 0, 0,  0, 63, 0, 1));
    tbl.push_back(mk("t3_ld0",   0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 1));
    tbl.push_back(mk("t3_dsat1", 0, 1, 0, 1, 0, 0, 0,  0,  0, 1, 1));
    tbl.push_back(mk("t3_dsat2", 0, 1, 0, 1, 0, 0, 0,  0,  0, 1, 1));
    tbl.push_back(mk("t3_idle",  0, 0, 0, 1, 0, 0, 0,  0,  0, 0, 1));
    tbl.push_back(mk("t3_ld63",  0, 0, 1, 1, 0, 1, 0, 63, 63, 0, 1));
    tbl.push_back(mk("t3_usat",  0, 1, 1, 1, 0, 0, 0,  0, 63, 1, 1));
    tbl.push_back(mk("t3_oclr",  0, 0, 1, 0, 0, 0, 1,  0, 63, 0, 0));
    tbl.push_back(mk("dir_ld10", 0, 0, 1, 0, 0, 1, 0, 10, 10, 0, 0));
    tbl.push_back(mk("dir_up",   0, 1, 1, 0, 0, 0, 0,  0, 11, 0, 0));
    tbl.push_back(mk("dir_dn",   0, 1, 0, 0, 0, 0, 0,  0, 10, 0, 0));
    tbl.push_back(mk("dir_sat",  0, 1, 1, 1, 0, 0, 0,  0, 11, 0, 0));
    tbl.push_back(mk("t4_ld40",  0, 0, 1, 0, 0, 1, 0, 40, 40, 0, 0));
    tbl.push_back(mk("t4_prio",  0, 1, 1, 0, 1, 1, 0,  5,  0, 0, 0));
    tbl.push_back(mk("t4_ldstp", 0, 1, 1, 0, 0, 1, 0, 63, 63, 0, 0));
    tbl.push_back(mk("t4_wrap",  0, 1, 1, 0, 0, 0, 0,  0,  0, 0, 1));
    tbl.push_back(mk("t4_ld63",  0, 0, 1, 0, 0, 1, 0, 63, 63, 0, 1));
    tbl.push_back(mk("t4_setwin",0, 1, 1, 0, 0, 0, 1,  0,  0, 0, 1));
    tbl.push_back(mk("t4_oclr",  0, 0, 1, 0, 0, 0, 1,  0,  0, 0, 0));
    tbl.push_back(mk("t4_ld63b", 0, 0, 1, 0, 0, 1, 0, 63, 63, 0, 0));
    tbl.push_back(mk("t4_clrwin",0, 1, 1, 0, 1, 0, 0,  0,  0, 0, 0));
    tbl.push_back(mk("t4_ld62",  0, 0, 1, 0, 0, 1, 0, 62, 62, 0, 0));
    tbl.push_back(mk("t4_63",    0, 1, 1, 0, 0, 0, 0,  0, 63, 1, 0));
    tbl.push_back(mk("t4_hold",  0, 0, 1, 0, 0, 0, 0,  0, 63, 0, 0));
    tbl.push_back(mk("t5_wrap",  0, 1, 1, 0, 0, 0, 0,  0,  0, 0, 1));
    tbl.push_back(mk("t5_ld16",  0, 0, 1, 0, 0, 1, 0, 16, 16, 0, 1));
    tbl.push_back(mk("t5_17",    0, 1, 1, 0, 0, 0, 0,  0, 17, 0, 1));
    tbl.push_back(mk("b_ldclamp",1, 0, 1, 0, 0, 1, 0, 15,  9, 0, 0));
    tbl.push_back(mk("b_wrap",   1, 1, 1, 0, 0, 0, 0,  0,  0, 0, 1));
    tbl.push_back(mk("b_dnwrap", 1, 1, 0, 0, 0, 0, 0,  0,  9, 0, 1));
    tbl.push_back(mk("b_dn8",    1, 1, 0, 0, 0, 0, 0,  0,  8, 0, 1));
    tbl.push_back(mk("b_up9",    1, 1, 1, 1, 0, 0, 0,  0,  9, 1, 1));
    tbl.push_back(mk("b_usat",   1, 1, 1, 1, 0, 0, 0,  0,  9, 1, 1));
    for (int i = 0; i < tbl.size(); i++) drive_vec(tbl[i]);

    // Asynchronous reset between edges, with count=17 and ovf set.
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("t5_async.count", int'(a_count), 0);
    chk("t5_async.tc",    int'(a_tc),    0);
    chk("t5_async.ovf",   int'(a_ovf),   0);
    chk("t5_async.b_count", int'(b_count), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_vec(mk("t5_resume", 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
`else
    for (int i = 1; i <= 12; i++)
      drive_vec(mk("t6_pre", 0, 1, 1, 0, 0, 0, 0, 0, i / 4, 0, 0));
    drive_vec(mk("t6_ph1", 0, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0));
    drive_vec(mk("t6_ph2", 0, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0));
    for (int i = 0; i < 3; i++)
      drive_vec(mk("t6_gap", 0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0));
    drive_vec(mk("t6_ph3", 0, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0));
    drive_vec(mk("t6_step", 0, 1, 1, 0, 0, 0, 0, 0, 4, 0, 0));
    drive_vec(mk("t6_ld", 0, 0, 1, 0, 0, 1, 0, 62, 62, 0, 0));
    for (int i = 1; i <= 4; i++)
      drive_vec(mk("t6_tc", 0, 1, 1, 0, 0, 0, 0, 0, (i == 4) ? 63 : 62, (i == 4), 0));
`endif

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_updown.md
Name: counter_updown

Overview:
Parametrised successor to the team's free-running 6-bit counter. It is an up/down counter with:
- a configurable maximum value,
- synchronous clear and parallel load,
- a count enable,
- wrap or saturate boundary mode,
- a registered terminal-count pulse and a sticky overflow flag.

It serves as the general event/timer counter for datapath and control blocks.

Parameters:
WIDTH, 6, counter width in bits.
MAX_VAL, 2**WIDTH-1, highest count value; legal range 1..2**WIDTH-1.
PRESCALE, 4, enabled cycles per count step; used only when COUNTER_PRESCALE_EN is defined; legal range >= 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous active-low reset (0 = reset asserted).
en  input  1  count enable; one step per enabled cycle.
up  input  1  direction: 1 = increment, 0 = decrement.
sat  input  1  boundary mode: 1 = saturate, 0 = wrap.
clr  input  1  synchronous clear of count, tc and ovf.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  value for load.
ovf_clr  input  1  synchronous clear of ovf only.
count  output  WIDTH  current count, registered.
tc  output  1  terminal-count pulse, registered.
ovf  output  1  sticky overflow flag, registered.

Behaviour:
- Reset (rst=0, asynchronous): count=0, tc=0, ovf=0 immediately. Internal prescaler is also zeroed. Release is synchronous to the next clk edge.
- Per-edge priority: clr > load > en step > hold.
- clr=1: count=0, tc=0, ovf=0.
- load=1 (clr=0): count = min(load_val, MAX_VAL); tc=0; ovf unchanged.
- Step up:
  - count<MAX_VAL: count+1.
  - count==MAX_VAL, sat=0: count=0, ovf=1.
  - count==MAX_VAL, sat=1: count stays MAX_VAL, ovf=1.
- Step down:
  - count>0: count-1.
  - count==0, sat=0: count=MAX_VAL, ovf=1.
  - count==0, sat=1: count stays 0, ovf=1.
- tc=1 for exactly one cycle after any step whose resulting count is the terminal value. Terminal value is MAX_VAL when up=1, 0 when up=0. tc is 0 after every cycle in which no step occurs.
- A saturated step re-asserts tc. With en held high at the boundary in sat mode, tc stays high.
- ovf_clr=1 clears ovf unless an overflow step occurs in the same cycle. In that case ovf=1 (set wins).
- clr wins over ovf_clr and over any simultaneous step.
- Changing up or sat mid-count takes effect on the next step; no other side effect.
- en=0: count, ovf hold; tc=0.
- Latency: count reflects a step one edge after en is sampled high.
- With WIDTH=6 and MAX_VAL=63, behaviour matches the legacy 6-bit counter when en=1, up=1, sat=0.
- All arithmetic is WIDTH bits; no intermediate value exceeds WIDTH+1 bits.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined:
  - An internal prescaler of ceil(log2(PRESCALE)) bits counts enabled cycles.
  - A count step occurs only on the enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - The prescaler holds when en=0 and is zeroed by rst, clr and load.
  - tc and ovf follow the actual steps only.
- Not defined: no prescaler logic; a step occurs on every enabled cycle; PRESCALE is ignored.

Test Plan:
1. rst=0 for 2 cycles, then rst=1, en=1, up=1, sat=0; after 5 rising edges -> count=5, tc=0, ovf=0.
2. load=1, load_val=61 for one cycle, then en=1, up=1, sat=0 -> count 61,62,63,0,1; tc=1 only in the cycle count=63; ovf=1 from the cycle count=0 onward.
3. Wrap down: load 1, en=1, up=0, sat=0 -> count 0, then 63; ovf=1. With sat=1 from count=0 -> count stays 0, tc held 1, ovf=1.
4. Priority: clr=1, load=1, en=1 in the same cycle at count=40 -> count=0, ovf=0. Then load=1, load_val=63, en=1 -> count=63 (load beats step). With ovf=1, ovf_clr=1 during a wrapping step -> ovf stays 1.
5. Asynchronous reset mid-count: assert rst=0 between edges at count=17 -> count=0, tc=0, ovf=0 before the next edge. Counting resumes from 1 on the first edge after release.
6. COUNTER_PRESCALE_EN defined, PRESCALE=4: en=1 for 12 cycles from count=0 -> count=3. Drop en for 3 cycles mid-prescale -> no step; the prescaler phase resumes where it stopped.
